parking_slot_ctrl: RTL

- Downstream consumer of the keypad decoder's `value` output (4-bit slot number, level-held, 0 = none/invalid).
- Turns slot selections into per-slot occupancy updates: a free slot becomes an entry, an occupied slot becomes an exit.
- Runs a timed gate-open FSM for each entry or exit.
- Drives free-slot count and full/empty flags for the display and LED stages.

---
 rtl/parking_slot_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/parking_slot_ctrl.sv
// rtl/parking_slot_ctrl.sv - parking slot occupancy tracker with timed gate FSM (optional PARK_STATS_EN entry counter)
module parking_slot_ctrl #(
    parameter int NUM_SLOTS   = 6,
    parameter int GATE_CYCLES = 100000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     key_value,
    output logic [NUM_SLOTS-1:0]           occupied,
    output logic [$clog2(NUM_SLOTS+1)-1:0] free_count,
    output logic                           full,
    output logic                           empty,
    output logic                           gate_open,
    output logic                           gate_dir,
    output logic [3:0]                     last_slot,
    output logic                           err,
`ifdef PARK_STATS_EN
    output logic [15:0]                    total_entries,
`endif
    output logic                           drop
);

    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [3:0]    MAX_KEY    = 4'(NUM_SLOTS);
    localparam logic [CW-1:0] ALL_FREE   = CW'(NUM_SLOTS);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(GATE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        OPEN
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             prev_key_q;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_SLOTS-1:0]   occ_q, occ_d;
    logic [CW-1:0]          free_q, free_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   gate_open_q, gate_open_d;
    logic                   gate_dir_q, gate_dir_d;
    logic [3:0]             last_slot_q, last_slot_d;
    logic                   err_q, err_d;
    logic                   drop_q, drop_d;
`ifdef PARK_STATS_EN
    logic [15:0]            entries_q, entries_d;
`endif

    // A command is a fresh non-zero key; the decoder holds its value, so a repeat needs an intervening change
    logic                   new_key;
    logic                   key_valid;
    logic [NUM_SLOTS-1:0]   slot_mask;
    logic                   slot_free;

    // Decode the incoming key against the previous cycle's value and the current occupancy
    always_comb begin
        new_key   = (key_value != prev_key_q) && (key_value != 4'd0);
        key_valid = (key_value <= MAX_KEY);
        slot_mask = NUM_SLOTS'(1) << (key_value - 4'd1);
        slot_free = ~|(occ_q & slot_mask);
    end

    // Next-state and output logic for the gate FSM, occupancy and counters
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        occ_d       = occ_q;
        free_d      = free_q;
        gate_open_d = gate_open_q;
        gate_dir_d  = gate_dir_q;
        last_slot_d = last_slot_q;
        err_d       = new_key && !key_valid;
        drop_d      = 1'b0;
`ifdef PARK_STATS_EN
        entries_d   = entries_q;
`endif

        case (state_q)
            IDLE: begin
                if (new_key && key_valid) begin
                    occ_d       = occ_q ^ slot_mask;
                    last_slot_d = key_value;
                    gate_dir_d  = slot_free;
                    gate_open_d = 1'b1;
                    timer_d     = TIMER_LOAD;
                    state_d     = OPEN;
                    // Entry only happens on a free slot and exit on an occupied one, so this never wraps
                    if (slot_free) begin
                        free_d = free_q - CW'(1);
`ifdef PARK_STATS_EN
                        if (entries_q != 16'hFFFF) begin
                            entries_d = entries_q + 16'd1;
                        end
`endif
                    end else begin
                        free_d = free_q + CW'(1);
                    end
                end
            end
            OPEN: begin
                // Keys arriving while the gate is busy are discarded, not queued
                drop_d = new_key && key_valid;
                if (timer_q == '0) begin
                    gate_open_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flags are derived from the next count so they land in the same edge as free_count
        full_d  = (free_d == '0);
        empty_d = (free_d == ALL_FREE);
    end

    // State register with synchronous reset; reset also aborts any open gate
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_key_q  <= 4'd0;
            timer_q     <= '0;
            occ_q       <= '0;
            free_q      <= ALL_FREE;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            gate_open_q <= 1'b0;
            gate_dir_q  <= 1'b0;
            last_slot_q <= 4'd0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
`ifdef PARK_STATS_EN
            entries_q   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            prev_key_q  <= key_value;
            timer_q     <= timer_d;
            occ_q       <= occ_d;
            free_q      <= free_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            gate_open_q <= gate_open_d;
            gate_dir_q  <= gate_dir_d;
            last_slot_q <= last_slot_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
`ifdef PARK_STATS_EN
            entries_q   <= entries_d;
`endif
        end
    end

    assign occupied   = occ_q;
    assign free_count = free_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign gate_open  = gate_open_q;
    assign gate_dir   = gate_dir_q;
    assign last_slot  = last_slot_q;
    assign err        = err_q;
    assign drop       = drop_q;
`ifdef PARK_STATS_EN
    assign total_entries = entries_q;
`endif

endmodule
